// File: rtl/mux_rr_int_pkg.sv
// Shared constants and helpers for the N-channel round-robin integer mux.
// Holds default sizes, arbitration mode codes and the channel-index width function.
package mux_rr_int_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 32;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Width needed to index n channels, never below one bit.
  function automatic int ch_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mux_rr_int_if.sv
// Producer/consumer bundle for mux_rr_int: per-channel requests in, one registered word out.
// The slave modport is the mux side; the master modport is the environment side.
interface mux_rr_int_if
  import mux_rr_int_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH_W   = ch_width(DEF_NUM_CH)
);

  logic [NUM_CH-1:0]        in_sel;
  logic [0:NUM_CH*DATA_W-1] in_data;
  logic [NUM_CH-1:0]        in_ack;
  logic [0:DATA_W-1]        out_data;
  logic                     out_resp;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;
  logic                     out_busy;

  modport master (
    output in_sel, in_data, out_ready,
    input  in_ack, out_data, out_resp, out_ch, out_busy
  );

  modport slave (
    input  in_sel, in_data, out_ready,
    output in_ack, out_data, out_resp, out_ch, out_busy
  );

endinterface

// File: rtl/mux_rr_arb.sv
// Combinational channel arbiter: round-robin from a pointer, or fixed lowest-index priority.
// Produces a one-hot grant plus its encoded index; no state lives here.
module mux_rr_arb
  import mux_rr_int_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CH_W    = ch_width(DEF_NUM_CH),
  parameter int RR_MODE = MODE_RR
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_valid
);

  int idx;

  // Scan NUM_CH candidates starting at the pointer; the modulo keeps
  // non-power-of-two channel counts from producing out-of-range indices.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if (enable) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (RR_MODE == MODE_FIXED) ? k : (int'(ptr) + k) % NUM_CH;
        if (!grant_valid && req[idx]) begin
          grant[idx]  = 1'b1;
          grant_idx   = idx[CH_W-1:0];
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_rr_int.sv
// N-channel integer mux with arbitrated acceptance into a single-entry output register.
// Output presents data with out_resp under an out_ready handshake; one word per cycle peak.
module mux_rr_int
  import mux_rr_int_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CH_W    = ch_width(DEF_NUM_CH),
  parameter int RR_MODE = MODE_RR
) (
  input logic         clk,
  input logic         reset_n,
  mux_rr_int_if.slave bus
);

  if (NUM_CH < 2 || NUM_CH > 16 || CH_W != ch_width(NUM_CH)) begin : g_param_err
    $error("mux_rr_int: NUM_CH must be 2..16 and CH_W must equal ch_width(NUM_CH)");
  end

  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   next_ptr;
  logic [CH_W-1:0]   grant_idx;
  logic [NUM_CH-1:0] grant;
  logic              grant_valid;
  logic              load;
  logic [0:DATA_W-1] words [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slice
    assign words[i] = bus.in_data[i*DATA_W +: DATA_W];
  end

  // Register is free when empty or being drained on this edge.
  assign load = !bus.out_resp || bus.out_ready;

  // Gating enable with reset_n keeps in_ack low while reset is held.
  mux_rr_arb #(
    .NUM_CH  (NUM_CH),
    .CH_W    (CH_W),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req         (bus.in_sel),
    .ptr         (ptr),
    .enable      (load && reset_n),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign bus.in_ack = grant;
  assign next_ptr   = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_data <= '0;
      bus.out_ch   <= '0;
      bus.out_resp <= 1'b0;
      bus.out_busy <= 1'b0;
      ptr          <= '0;
    end else begin
      if (grant_valid) begin
        bus.out_data <= words[grant_idx];
        bus.out_ch   <= grant_idx;
        bus.out_resp <= 1'b1;
        if (RR_MODE == MODE_RR) ptr <= next_ptr;
      end else if (load) begin
        bus.out_resp <= 1'b0;
      end
      bus.out_busy <= (|bus.in_sel) && bus.out_resp && !bus.out_ready;
    end
  end

endmodule

// File: tb/tb_mux_rr_int.sv
// Directed bench for mux_rr_int: RR and fixed-priority 4-channel instances plus a 3-channel RR.
// Registered outputs are sampled 1 time unit after the rising edge.
module tb_mux_rr_int;
  import mux_rr_int_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux_rr_int_if #(.NUM_CH(4), .DATA_W(32), .CH_W(2)) b4 ();
  mux_rr_int_if #(.NUM_CH(4), .DATA_W(32), .CH_W(2)) bf ();
  mux_rr_int_if #(.NUM_CH(3), .DATA_W(32), .CH_W(2)) b3 ();

  mux_rr_int #(.NUM_CH(4), .DATA_W(32), .CH_W(2), .RR_MODE(MODE_RR)) u_rr4 (
    .clk(clk), .reset_n(reset_n), .bus(b4));
  mux_rr_int #(.NUM_CH(4), .DATA_W(32), .CH_W(2), .RR_MODE(MODE_FIXED)) u_fx4 (
    .clk(clk), .reset_n(reset_n), .bus(bf));
  mux_rr_int #(.NUM_CH(3), .DATA_W(32), .CH_W(2), .RR_MODE(MODE_RR)) u_rr3 (
    .clk(clk), .reset_n(reset_n), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out4(input string tag, input logic resp, input logic [31:0] data,
                          input logic [1:0] ch);
    chk({tag, "_resp"}, 32'(b4.out_resp), 32'(resp));
    chk({tag, "_data"}, b4.out_data, data);
    chk({tag, "_ch"}, 32'(b4.out_ch), 32'(ch));
  endtask

  initial begin
    reset_n = 1'b0;
    b4.in_sel = 4'hF; b4.in_data = '0; b4.out_ready = 1'b1;
    bf.in_sel = '0;   bf.in_data = '0; bf.out_ready = 1'b1;
    b3.in_sel = '0;   b3.in_data = '0; b3.out_ready = 1'b1;
    #2;
    chk_out4("rst", 1'b0, 32'h0, 2'd0);
    chk("rst_busy", 32'(b4.out_busy), 32'h0);
    chk("rst_ack_gated", 32'(b4.in_ack), 32'h0);
    step();
    step();
    reset_n = 1'b1;

    // Single request on ch2
    b4.in_sel = 4'b0100;
    b4.in_data = {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
    #1 chk("t1_ack", 32'(b4.in_ack), 32'h4);
    step();
    chk_out4("t1_out", 1'b1, 32'hDEAD_BEEF, 2'd2);

    // Pointer now 3: ch3 beats ch0
    b4.in_sel = 4'b1001;
    b4.in_data = {32'hA0, 32'h0, 32'h0, 32'hA3};
    #1 chk("t1_ptr3_ack", 32'(b4.in_ack), 32'h8);
    step();
    chk_out4("t1_ptr3_out", 1'b1, 32'hA3, 2'd3);

    // All four continuously requesting: strict rotation, no bubbles
    b4.in_sel = 4'hF;
    b4.in_data = {32'h10, 32'h11, 32'h12, 32'h13};
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_ack", 32'(b4.in_ack), 32'(1 << (k % 4)));
      step();
      chk_out4("rr_out", 1'b1, 32'h10 + 32'(k % 4), 2'(k % 4));
    end
    b4.in_sel = 4'h0;
    #1 chk("idle_ack", 32'(b4.in_ack), 32'h0);
    step();
    chk_out4("idle_hold", 1'b0, 32'h13, 2'd3);

    // Backpressure: 0x55 held for three cycles while ch0 waits
    b4.in_sel = 4'b0001;
    b4.in_data = {32'h55, 32'h0, 32'h0, 32'h0};
    #1 chk("bp_load_ack", 32'(b4.in_ack), 32'h1);
    step();
    chk_out4("bp_load", 1'b1, 32'h55, 2'd0);
    b4.out_ready = 1'b0;
    b4.in_sel = 4'b0011;
    b4.in_data = {32'h66, 32'h99, 32'h0, 32'h0};
    for (int h = 0; h < 3; h++) begin
      #1 chk("bp_ack", 32'(b4.in_ack), 32'h0);
      step();
      chk_out4("bp_hold", 1'b1, 32'h55, 2'd0);
      chk("bp_busy", 32'(b4.out_busy), 32'h1);
      b4.in_sel = 4'b0001;
    end
    b4.out_ready = 1'b1;
    #1 chk("bp_release_ack", 32'(b4.in_ack), 32'h1);
    step();
    chk_out4("bp_release", 1'b1, 32'h66, 2'd0);
    chk("bp_busy_clr", 32'(b4.out_busy), 32'h0);
    b4.in_sel = 4'h0;
    step();
    chk("bp_drain", 32'(b4.out_resp), 32'h0);

    // Fixed priority: ch1 starves ch3
    bf.in_sel = 4'b1010;
    bf.in_data = {32'h0, 32'h21, 32'h0, 32'h23};
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("fx_ack", 32'(bf.in_ack), 32'h2);
      step();
      chk("fx_ch", 32'(bf.out_ch), 32'h1);
      chk("fx_data", bf.out_data, 32'h21);
    end
    bf.in_sel = 4'h0;

    // Three channels: pointer wraps 2 -> 0
    b3.in_sel = 3'b100;
    b3.in_data = {32'h30, 32'h31, 32'h32};
    #1 chk("n3_ack2", 32'(b3.in_ack), 32'h4);
    step();
    chk("n3_ch2", 32'(b3.out_ch), 32'h2);
    chk("n3_data2", b3.out_data, 32'h32);
    b3.in_sel = 3'b101;
    #1 chk("n3_wrap_ack", 32'(b3.in_ack), 32'h1);
    step();
    chk("n3_wrap_ch", 32'(b3.out_ch), 32'h0);
    chk("n3_wrap_data", b3.out_data, 32'h30);
    #1 chk("n3_next_ack", 32'(b3.in_ack), 32'h4);
    step();
    chk("n3_next_ch", 32'(b3.out_ch), 32'h2);
    b3.in_sel = 3'b000;

    // Asynchronous reset while holding a word
    b4.in_sel = 4'b0010;
    b4.in_data = {32'h0, 32'h77, 32'h0, 32'h0};
    #1 chk("ar_ack", 32'(b4.in_ack), 32'h2);
    step();
    chk_out4("ar_load", 1'b1, 32'h77, 2'd1);
    b4.in_sel = 4'b1000;
    b4.out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_out4("ar_async", 1'b0, 32'h0, 2'd0);
    chk("ar_ack_gated", 32'(b4.in_ack), 32'h0);
    step();
    step();
    reset_n = 1'b1;
    b4.out_ready = 1'b1;
    b4.in_sel = 4'b1010;
    b4.in_data = {32'h0, 32'hB1, 32'h0, 32'hB3};
    #1 chk("ar_ptr0_ack", 32'(b4.in_ack), 32'h2);
    step();
    chk_out4("ar_ptr0_out", 1'b1, 32'hB1, 2'd1);
    chk("ar_ch3_ack", 32'(b4.in_ack), 32'h8);
    step();
    chk_out4("ar_ch3_out", 1'b1, 32'hB3, 2'd3);
    b4.in_sel = 4'h0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
